i2c_arbiter: RTL
================

# i2c_arbiter

Shares one `i2c_master` instance between up to four transaction requesters, for example the RTC time reader and an RTC time setter. It does not change the bus protocol.
- Each requester presents a 32-bit `ctrl_data` word and holds `req` until it gets `done`.
- The arbiter picks one requester, issues the `wr_ctrl` pulse, tracks `status` busy/ready, and returns the read byte plus a success flag.
- A timeout guards against a master that never starts or never finishes.

## Interface
- `c_ports`, default 2: number of requesters, 1..4.
- `c_timeout_bits`, default 20: a wait exceeding 2^`c_timeout_bits` cycles in `WAIT_BUSY` or `WAIT_DONE` aborts the transaction.
- `clk`  in  1: system clock, shared with `i2c_master`.
- `reset`  in  1: synchronous, active-high.
- `req`  in  `c_ports`: per-requester request, level, held until `done`.
- `ctrl_data_i`  in  32*`c_ports`: requester k's word in bits [32k+31:32k], same format as the `i2c_master` `ctrl_data`.
- `grant`  out  `c_ports`: one-hot, high for the whole transaction of the owning requester.
- `done`  out  `c_ports`: one-cycle pulse to the owner at transaction end.
- `ok`  out  1: valid with `done`; 1 means the master finished with `status[28]` (ready) set, 0 means timeout or not ready.
- `rdata`  out  8: `status[7:0]` captured at end; held until the next `done`.
- `ctrl_data_o`  out  32: to `i2c_master.ctrl_data`.
- `wr_ctrl_o`  out  1: to `i2c_master.wr_ctrl`.
- `status_i`  in  32: from `i2c_master.status`; bit 31 is busy, bit 28 is ready.

## Operation
- States are `IDLE`, `ISSUE`, `WAIT_BUSY`, `WAIT_DONE`, `FINISH`.
- `IDLE`:
  - If any `req` is set and `status_i[31]`=0: pick a winner, latch its `ctrl_data_i` into `ctrl_data_o`, set `grant`, go to `ISSUE`.
  - If busy is still set, stay in `IDLE`.
- `ISSUE`: `wr_ctrl_o`=1 for exactly this cycle; clear the timeout counter; go to `WAIT_BUSY`.
- `WAIT_BUSY`:
  - On `status_i[31]`=1, go to `WAIT_DONE`.
  - On counter terminal value, go to `FINISH` with `ok`=0.
- `WAIT_DONE`:
  - On `status_i[31]`=0, capture `rdata`=`status_i[7:0]` and `ok`=`status_i[28]`, then go to `FINISH`.
  - On counter terminal value, go to `FINISH` with `ok`=0 and `rdata` unchanged.
- `FINISH`: pulse `done[owner]`, clear `grant`, go to `IDLE`.
- Arbitration is round-robin. The pointer moves to winner+1 (mod `c_ports`) at grant; the search starts at the pointer.
- `ctrl_data_o` is held stable from grant until the next grant. It does not change during a transaction even if `ctrl_data_i` changes.
- If `req` deasserts mid-transaction, the transaction still completes and `done` still pulses. The arbiter does not re-grant that port unless `req` is high again in `IDLE`.
- If a requester keeps `req` high in the cycle after `done`, that counts as a new request.
- The timeout counter is `c_timeout_bits`+1 wide, saturating. It is cleared in `ISSUE`, increments in the wait states, and the terminal value is bit[`c_timeout_bits`]=1.

## Timing
- Values after `reset` (synchronous, in any state): `IDLE`, round-robin pointer 0, all outputs 0 (`grant`, `done`, `ok`, `rdata`, `ctrl_data_o`, `wr_ctrl_o`).
- A reset mid-transaction does not pulse `done`. The master may still be busy; `IDLE` waits for busy to clear before the next grant.
- Request cycle sequence, with `req` sampled high in `IDLE` at cycle N:
  - N+1: `grant`, `ctrl_data_o` and `wr_ctrl_o` (`ISSUE`) all become visible.
  - N+2: `WAIT_BUSY`.
- Completion: busy is sampled low in `WAIT_DONE` at cycle M, `done`/`ok`/`rdata` are valid at M+1, and the earliest next `wr_ctrl_o` is at M+3.
- The minimum transaction is 5 cycles with an instantly toggling master.
- Simultaneous requests in `IDLE`: exactly one grant per `IDLE` cycle; the others wait without loss.

## Configuration
- `I2C_ARBITER_PRIORITY_EN` defined: fixed priority, lowest index wins, and the pointer is unused. Port 0 (the RTC time setter) can then starve the others.
- Undefined (default): round-robin as above.

## Structure
- Shared package `i2c_pkg`:
  - status bit index constants: `BUSY_BIT`=31, `READY_BIT`=28, `RDATA_LSB`=0.
  - the `ctrl_data` read-flag bit 31.
  - the state enum typedef.
- One sub-module, `i2c_rr_pick`: combinational winner select from `req` and the pointer, with the `I2C_ARBITER_PRIORITY_EN` variant inside it.

## Test plan
- Single requester, master model sets busy 3 cycles after `wr_ctrl` and clears it 40 cycles later with `status`=0x10000025 (ready set, `rdata` 0x25) → `wr_ctrl_o` exactly one cycle, `done[0]` one cycle, `ok`=1, `rdata`=0x25.
- `req`=2'b11 held continuously, round-robin build → grants alternate 0,1,0,1 over 4 transactions. With `I2C_ARBITER_PRIORITY_EN` → port 0 every time.
- Master never raises busy, `c_timeout_bits`=4 → `done` 17–18 cycles after `ISSUE`, `ok`=0, `rdata` keeps its previous value.
- `ctrl_data_i[0]` changes from 0x806F0000 to 0x006F0620 during `WAIT_DONE` → `ctrl_data_o` stays 0x806F0000 until the next grant.
- `reset` asserted in `WAIT_DONE` while the master stays busy 10 more cycles with `req[1]` high → no `done`, all outputs 0, next `wr_ctrl_o` only after busy falls.
- `req[1]` dropped during `WAIT_DONE` → `done[1]` still pulses, and no new grant to port 1.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared constants and FSM state type for the i2c_master request arbiter.
package i2c_pkg;

    localparam int unsigned BUSY_BIT    = 31;
    localparam int unsigned READY_BIT   = 28;
    localparam int unsigned RDATA_LSB   = 0;
    localparam int unsigned CTRL_RD_BIT = 31;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitBusy,
        StWaitDone,
        StFinish
    } arb_state_e;

endpackage

// File: rtl/i2c_rr_pick.sv
// Combinational winner select; round-robin from ptr by default, fixed lowest-index
// priority when I2C_ARBITER_PRIORITY_EN is defined.
module i2c_rr_pick import i2c_pkg::*; #(
    parameter int unsigned c_ports = 2
) (
    input  logic [c_ports-1:0] req,
    input  logic [1:0]         ptr,
    output logic               valid,
    output logic [1:0]         win
);

    localparam int NP = int'(c_ports);

`ifdef I2C_ARBITER_PRIORITY_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    always_comb begin
        valid = 1'b0;
        win   = '0;
        for (int i = NP - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                win   = 2'(i);
            end
        end
    end
`else
    // Outer loop is the distance from ptr, so the first hit is the round-robin winner.
    always_comb begin
        valid = 1'b0;
        win   = '0;
        for (int d = 0; d < NP; d++) begin
            for (int j = 0; j < NP; j++) begin
                if (!valid && req[j] && (j == ((int'(ptr) + d) % NP))) begin
                    valid = 1'b1;
                    win   = 2'(j);
                end
            end
        end
    end
`endif

endmodule

// File: rtl/i2c_arbiter.sv
// Shares one i2c_master between up to four requesters with timeout protection.
// Define I2C_ARBITER_PRIORITY_EN for fixed lowest-index priority instead of round-robin.
module i2c_arbiter import i2c_pkg::*; #(
    parameter int unsigned c_ports        = 2,
    parameter int unsigned c_timeout_bits = 20
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [c_ports-1:0]     req,
    input  logic [32*c_ports-1:0]  ctrl_data_i,
    output logic [c_ports-1:0]     grant,
    output logic [c_ports-1:0]     done,
    output logic                   ok,
    output logic [7:0]             rdata,
    output logic [31:0]            ctrl_data_o,
    output logic                   wr_ctrl_o,
    input  logic [31:0]            status_i
);

    arb_state_e              state;
    logic [1:0]              ptr;
    logic [c_timeout_bits:0] tmo;
    logic [c_timeout_bits:0] tmo_next;
    logic                    tmo_end;
    logic                    busy;
    logic                    pick_valid;
    logic [1:0]              pick_win;
    logic                    unused_status;

    assign busy          = status_i[BUSY_BIT];
    assign tmo_end       = tmo[c_timeout_bits];
    assign tmo_next      = tmo_end ? tmo : tmo + 1'b1;
    assign unused_status = ^{status_i[30:29], status_i[27:8]};

    i2c_rr_pick #(
        .c_ports (c_ports)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .valid (pick_valid),
        .win   (pick_win)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= StIdle;
            ptr         <= '0;
            tmo         <= '0;
            grant       <= '0;
            done        <= '0;
            ok          <= 1'b0;
            rdata       <= '0;
            ctrl_data_o <= '0;
            wr_ctrl_o   <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    // A master left busy by a reset must finish before the next grant.
                    if (pick_valid && !busy) begin
                        for (int k = 0; k < int'(c_ports); k++) begin
                            grant[k] <= (pick_win == 2'(k));
                        end
                        ctrl_data_o <= ctrl_data_i[32*int'(pick_win) +: 32];
                        ptr         <= (int'(pick_win) == int'(c_ports) - 1) ? 2'd0
                                                                            : pick_win + 2'd1;
                        wr_ctrl_o   <= 1'b1;
                        state       <= StIssue;
                    end
                end
                StIssue: begin
                    wr_ctrl_o <= 1'b0;
                    tmo       <= '0;
                    state     <= StWaitBusy;
                end
                StWaitBusy: begin
                    tmo <= tmo_next;
                    if (busy) begin
                        state <= StWaitDone;
                    end else if (tmo_end) begin
                        ok    <= 1'b0;
                        done  <= grant;
                        state <= StFinish;
                    end
                end
                StWaitDone: begin
                    tmo <= tmo_next;
                    if (!busy) begin
                        rdata <= status_i[RDATA_LSB +: 8];
                        ok    <= status_i[READY_BIT];
                        done  <= grant;
                        state <= StFinish;
                    end else if (tmo_end) begin
                        ok    <= 1'b0;
                        done  <= grant;
                        state <= StFinish;
                    end
                end
                StFinish: begin
                    done  <= '0;
                    grant <= '0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
